// File: rtl/apa102_in_if.sv
// rtl/apa102_in_if.sv - memory write bus carrying packed pixel words out of apa102_in
interface apa102_in_if #(
  parameter int AW = 16
) ();
  logic [AW-1:0] write_address;
  logic [15:0]   write_data;
  logic          write_strobe;

  modport master (output write_address, write_data, write_strobe);
  modport slave  (input  write_address, write_data, write_strobe);
endinterface

// File: rtl/apa102_in.sv
// rtl/apa102_in.sv - APA102 stream receiver packing BGR pixels into 16-bit memory writes
module apa102_in #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clock_in,
  input  logic              data_in,
  input  logic [15:0]       start_address,
  input  logic [15:0]       word_count,
  apa102_in_if.master       bus,
  output logic              frame_done,
  output logic [15:0]       pixel_count,
  output logic [4:0]        brightness,
  output logic              header_error,
  output logic              overflow
);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {SYNC, FRAME, FLUSH} state_t;
  state_t state, state_n;

  logic          ck_s1, ck_s2, ck_prev, dt_s1, dt_s2;
  logic          rise;
  logic [IW-1:0] idle_cnt;
  logic          timeout_hit;
  logic [4:0]    zero_cnt;
  logic [4:0]    bit_cnt;
  logic [30:0]   shreg;
  logic [31:0]   w_word;
  logic [15:0]   words_left;
  logic [7:0]    acc;
  logic          fill;
  logic          pend_v;
  logic [15:0]   pend_d;

  logic          frame_start, commit, hdr_err, go_done;
  logic          emit_v, set_pend;
  logic [15:0]   emit_w;

  assign rise        = ck_s2 & ~ck_prev;
  assign timeout_hit = ~rise && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
  assign w_word      = {shreg, dt_s2};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_n;
  end

  // Next state and frame classification; FLUSH wins over anything sampled meanwhile
  always_comb begin
    state_n     = state;
    frame_start = 1'b0;
    commit      = 1'b0;
    hdr_err     = 1'b0;
    go_done     = 1'b0;
    case (state)
      SYNC: begin
        if (rise && !dt_s2 && zero_cnt == 5'd31) begin
          frame_start = 1'b1;
          state_n     = FRAME;
        end
      end
      FRAME: begin
        if (timeout_hit) begin
          state_n = FLUSH;
        end else if (rise && bit_cnt == 5'd31) begin
          if (w_word == 32'hFFFF_FFFF) begin
            state_n = FLUSH;
          end else if (w_word == 32'h0 && pixel_count == 16'h0) begin
            state_n = FRAME;
          end else if (w_word[31:29] != 3'b111) begin
            hdr_err = 1'b1;
            state_n = SYNC;
          end else begin
            commit = 1'b1;
          end
        end
      end
      FLUSH: begin
        go_done = 1'b1;
        state_n = SYNC;
      end
      default: state_n = SYNC;
    endcase
  end

  // Packer emit selection; pending second word, commit and flush never coincide
  always_comb begin
    emit_v   = 1'b0;
    emit_w   = 16'h0;
    set_pend = 1'b0;
    if (pend_v) begin
      emit_v = 1'b1;
      emit_w = pend_d;
    end else if (commit) begin
      emit_v = 1'b1;
      if (fill) begin
        emit_w   = {acc, w_word[23:16]};
        set_pend = 1'b1;
      end else begin
        emit_w = w_word[23:8];
      end
    end else if (go_done && fill) begin
      emit_v = 1'b1;
      emit_w = {acc, 8'h00};
    end
  end

  // Synchronizers, counters, packer and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_s1 <= 1'b0; ck_s2 <= 1'b0; ck_prev <= 1'b0;
      dt_s1 <= 1'b0; dt_s2 <= 1'b0;
      idle_cnt <= '0; zero_cnt <= '0; bit_cnt <= '0; shreg <= '0;
      words_left <= '0; acc <= '0; fill <= 1'b0; pend_v <= 1'b0; pend_d <= '0;
      bus.write_address <= '0; bus.write_data <= '0; bus.write_strobe <= 1'b0;
      frame_done <= 1'b0; pixel_count <= '0; brightness <= '0;
      header_error <= 1'b0; overflow <= 1'b0;
    end else begin
      ck_s1 <= clock_in; ck_s2 <= ck_s1; ck_prev <= ck_s2;
      dt_s1 <= data_in;  dt_s2 <= dt_s1;

      if (rise)                                  idle_cnt <= '0;
      else if (idle_cnt != IW'(TIMEOUT_CYCLES))  idle_cnt <= idle_cnt + 1'b1;

      if (state == FRAME || timeout_hit) zero_cnt <= '0;
      else if (rise)                     zero_cnt <= dt_s2 ? 5'd0 : zero_cnt + 5'd1;

      if (state == FRAME && rise) begin
        shreg   <= w_word[30:0];
        bit_cnt <= bit_cnt + 5'd1;
      end

      bus.write_strobe <= 1'b0;
      frame_done       <= go_done;
      header_error     <= hdr_err;
      pend_v           <= set_pend;

      if (bus.write_strobe) bus.write_address <= bus.write_address + 1'b1;

      if (commit) begin
        brightness  <= w_word[28:24];
        pixel_count <= pixel_count + 16'd1;
        if (fill) begin
          fill   <= 1'b0;
          pend_d <= w_word[15:0];
        end else begin
          fill <= 1'b1;
          acc  <= w_word[7:0];
        end
      end
      if (go_done) fill <= 1'b0;

      if (emit_v) begin
        if (words_left != 16'h0) begin
          bus.write_strobe <= 1'b1;
          bus.write_data   <= emit_w;
          words_left       <= words_left - 16'd1;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (frame_start) begin
        bit_cnt           <= '0;
        pixel_count       <= '0;
        overflow          <= 1'b0;
        bus.write_address <= ADDRESS_BUS_WIDTH'(start_address);
        words_left        <= word_count;
        fill              <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apa102_in.sv
// tb/tb_apa102_in.sv - scoreboard bench for apa102_in
module tb_apa102_in;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clock_in = 1'b0;
  logic        data_in = 1'b0;
  logic [15:0] start_address = 16'h0100;
  logic [15:0] word_count = 16'd16;
  logic        frame_done, header_error, overflow;
  logic [15:0] pixel_count;
  logic [4:0]  brightness;

  apa102_in_if #(.AW(16)) bus ();

  apa102_in #(.ADDRESS_BUS_WIDTH(16), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .clock_in(clock_in), .data_in(data_in),
    .start_address(start_address), .word_count(word_count), .bus(bus),
    .frame_done(frame_done), .pixel_count(pixel_count), .brightness(brightness),
    .header_error(header_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          hdr_cnt = 0;
  int          strobe_cnt = 0;
  logic [31:0] exp_q[$];
  int          stamps[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor and pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (bus.write_strobe) begin
        strobe_cnt++;
        stamps.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {bus.write_address, bus.write_data}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {16'h0, bus.write_address}, {16'h0, e[31:16]});
          chk("wr_data", {16'h0, bus.write_data}, {16'h0, e[15:0]});
        end
      end
      if (frame_done)   done_cnt++;
      if (header_error) hdr_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    data_in  = b;
    clock_in = 1'b0;
    wait_clk(4);
    clock_in = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic new_test();
    done_cnt = 0;
    hdr_cnt  = 0;
    stamps.delete();
  endtask

  task automatic end_test(input string tag, input int done_exp, input int hdr_exp);
    wait_clk(20);
    @(negedge clk);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_frame_done"}, done_cnt, done_exp);
    chk({tag, "_header_error"}, hdr_cnt, hdr_exp);
    exp_q.delete();
  endtask

  initial begin
    int sc;
    wait_clk(3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_addr", {16'h0, bus.write_address}, 32'h0);
    chk("rst_data", {16'h0, bus.write_data}, 32'h0);
    chk("rst_outs", {bus.write_strobe, frame_done, header_error, overflow, brightness, pixel_count}, 32'h0);

    // Single pixel, flushed on end frame
    new_test();
    exp_q.push_back({16'h0100, 16'hFF00});
    exp_q.push_back({16'h0101, 16'h0000});
    send_word(32'h0); send_word(32'hE1FF_0000); send_word(32'hFFFF_FFFF);
    end_test("one_pixel", 1, 0);
    chk("one_pixel_count", pixel_count, 1);
    chk("one_pixel_bright", brightness, 5'h01);
    chk("one_pixel_ovf", overflow, 0);

    // Two pixels, back-to-back strobes on the second one, no flush word
    new_test();
    exp_q.push_back({16'h0100, 16'h1122});
    exp_q.push_back({16'h0101, 16'h3344});
    exp_q.push_back({16'h0102, 16'h5566});
    send_word(32'h0); send_word(32'hE011_2233); send_word(32'hE044_5566); send_word(32'hFFFF_FFFF);
    end_test("two_pixel", 1, 0);
    chk("two_pixel_count", pixel_count, 2);
    chk("two_pixel_bright", brightness, 0);
    chk("two_pixel_strobes", stamps.size(), 3);
    if (stamps.size() == 3) chk("two_pixel_b2b", stamps[2] - stamps[1], 1);

    // Word budget of one: later words dropped, overflow sticky until next start
    new_test();
    word_count = 16'd1;
    exp_q.push_back({16'h0100, 16'hAABB});
    send_word(32'h0); send_word(32'hE1AA_BBCC); send_word(32'hE2DD_EEFF); send_word(32'hFFFF_FFFF);
    end_test("overflow", 1, 0);
    chk("overflow_set", overflow, 1);
    chk("overflow_bright", brightness, 5'h02);
    send_word(32'h0);
    wait_clk(10);
    chk("overflow_cleared", overflow, 0);
    chk("overflow_pixels_cleared", pixel_count, 0);
    word_count = 16'd16;

    // Bad header aborts to SYNC; a fresh start frame resyncs
    new_test();
    send_word(32'h0); send_word(32'h4012_3456);
    end_test("bad_header", 0, 1);
    new_test();
    exp_q.push_back({16'h0100, 16'h0102});
    exp_q.push_back({16'h0101, 16'h0300});
    send_word(32'h0); send_word(32'hE301_0203); send_word(32'hFFFF_FFFF);
    end_test("resync", 1, 0);
    chk("resync_count", pixel_count, 1);
    chk("resync_bright", brightness, 5'h03);

    // Clock stall after a pixel and 12 stray bits forces the flush
    new_test();
    exp_q.push_back({16'h0100, 16'hA1B2});
    exp_q.push_back({16'h0101, 16'hC300});
    send_word(32'h0); send_word(32'hE4A1_B2C3);
    for (int i = 0; i < 12; i++) send_bit(i[0]);
    clock_in = 1'b0;
    wait_clk(1200);
    end_test("timeout", 1, 0);
    chk("timeout_count", pixel_count, 1);

    // Reset in the middle of a pixel, then a clean frame
    new_test();
    send_word(32'h0);
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    sc = strobe_cnt;
    clock_in = 1'b0;
    data_in  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", {bus.write_strobe, frame_done, header_error, overflow, brightness, pixel_count}, 32'h0);
    chk("midrst_addr", {16'h0, bus.write_address}, 32'h0);
    rst = 1'b0;
    wait_clk(20);
    chk("midrst_no_write", strobe_cnt - sc, 0);
    chk("midrst_no_done", done_cnt, 0);
    new_test();
    exp_q.push_back({16'h0100, 16'h0A0B});
    exp_q.push_back({16'h0101, 16'h0C00});
    send_word(32'h0); send_word(32'hE60A_0B0C); send_word(32'hFFFF_FFFF);
    end_test("after_rst", 1, 0);
    chk("after_rst_count", pixel_count, 1);
    chk("after_rst_bright", brightness, 5'h06);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
